// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parametrised XNOR LFSR generator.
package lfsr_pkg;

  // Widest LFSR the step helper supports; callers zero-extend into it and truncate back.
  localparam int unsigned LFSR_MAX_W = 256;

  localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    RUN      = 2'd1,
    LOCKED   = 2'd2
  } lfsr_state_e;

  // One XNOR shift step; upper bits beyond the caller's width must be zero.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    logic fb;
    fb = ~^(state & taps);
    return {state[LFSR_MAX_W-2:0], fb};
  endfunction

endpackage

// File: rtl/lfsr_advance.sv
// Combinational word advance: STEPS chained single-bit LFSR steps.
module lfsr_advance
  import lfsr_pkg::*;
#(
  parameter int unsigned     WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR64_TAPS),
  parameter int unsigned     STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_c
);

  logic [WIDTH-1:0] chain [STEPS+1];

  assign chain[0] = state;

  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign chain[g+1] = WIDTH'(lfsr_step(LFSR_MAX_W'(chain[g]), LFSR_MAX_W'(TAPS)));
  end

  assign next_c = chain[STEPS];

endmodule

// File: rtl/lfsr_prng.sv
// LFSR pseudo-random word source with seed handshake, valid/ready output and lockup guard.
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH      = 64,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR64_TAPS),
  parameter int unsigned      STEPS      = 1,
  parameter bit               AUTO_START = 1'b0,
  parameter logic [WIDTH-1:0] RESET_SEED = '0,
  parameter int unsigned      CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_valid,
  output logic             seed_ready,
  output logic             seed_err,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup,
  output logic [CNT_W-1:0] word_cnt
);

  localparam lfsr_state_e FSM_RESET = AUTO_START ? RUN : UNSEEDED;

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] adv_c;
  logic [CNT_W-1:0] cnt_d;
  logic             err_d;
  logic             seed_ok, seed_bad, fire;

  lfsr_advance #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_advance (
    .state  (lfsr_q),
    .next_c (adv_c)
  );

  assign seed_ready = 1'b1;
  assign seed_ok    = seed_valid && !(&seed);
  assign seed_bad   = seed_valid && (&seed);
  assign out_data   = lfsr_q;

  // Next-state: a valid seed always wins the state; otherwise a fire advances it.
  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    cnt_d  = word_cnt;
    err_d  = seed_bad;
    fire   = 1'b0;
    case (fsm_q)
      RUN:      fire = out_ready;
      UNSEEDED: fire = 1'b0;
      LOCKED:   fire = 1'b0;
      default:  fire = 1'b0;
    endcase
    if (seed_ok) begin
      lfsr_d = seed;
      cnt_d  = '0;
      fsm_d  = RUN;
    end else if (fire) begin
      lfsr_d = adv_c;
      cnt_d  = word_cnt + CNT_W'(1);
      if (&adv_c) fsm_d = LOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q     <= FSM_RESET;
      lfsr_q    <= RESET_SEED;
      word_cnt  <= '0;
      seed_err  <= 1'b0;
      out_valid <= AUTO_START;
      lockup    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      lfsr_q    <= lfsr_d;
      word_cnt  <= cnt_d;
      seed_err  <= err_d;
      out_valid <= (fsm_d == RUN);
      lockup    <= (fsm_d == LOCKED);
    end
  end

endmodule
